// File: rtl/dma.sv
// dma -- single-channel word-copy DMA engine.
//
// A register port (stb/we/addr/data_in -> data_out/ack) programs a source
// word address (SRC), a destination word address (DST), a word count (CNT)
// and a control/status register (CTRL). A start moves CNT words from SRC to
// DST over a simple strobe/acknowledge master bus, one read then one write
// per word. Addresses are 22-bit word addresses that wrap modulo 2^22.
//
// Ports
//   clk       system clock, all state changes on the rising edge
//   rst       synchronous active-high reset
//   stb       register-port strobe
//   we        register-port write enable
//   addr      register select: 0 SRC, 1 DST, 2 CNT, 3 CTRL
//   data_in   register write data
//   data_out  register read data (combinational from addr)
//   ack       register-port acknowledge (equals stb)
//   m_stb     master strobe
//   m_we      master write enable
//   m_addr    master word address
//   m_din     master read data
//   m_dout    master write data (0 outside the write phase)
//   m_ack     master acknowledge
//   irq       level interrupt, done AND ie
//
// CTRL write: bit0 start, bit1 ie, any write clears done.
// CTRL read : bit0 busy, bit1 done, bit2 ie.
//
// Optional feature, macro DMA_FILL_EN: CTRL write bit2 selects fill mode,
// in which the read phase is skipped and the zero-extended SRC value is
// written to every destination word while SRC stays put. Because bit2 of the
// status view already carries ie, the fill flag reads back on CTRL bit3.

module dma (
  input  logic         clk,
  input  logic         rst,
  input  logic         stb,
  input  logic         we,
  input  logic [3:2]   addr,
  input  logic [31:0]  data_in,
  output logic [31:0]  data_out,
  output logic         ack,
  output logic         m_stb,
  output logic         m_we,
  output logic [23:2]  m_addr,
  input  logic [31:0]  m_din,
  output logic [31:0]  m_dout,
  input  logic         m_ack,
  output logic         irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_next;

  logic [21:0]  r_src;
  logic [21:0]  r_dst;
  logic [15:0]  r_cnt;
  logic [31:0]  r_buf;
  logic         r_ie;
  logic         r_done;

  logic         w_busy;
  logic         w_fill;
  logic         w_reg_wr;
  logic         w_ctrl_wr;
  logic         w_start;
  logic         w_last;
  logic         w_set_done;
  logic         w_unused_data;

`ifdef DMA_FILL_EN
  logic         r_fill;
  assign w_fill = r_fill;
`else
  assign w_fill = 1'b0;
`endif

  assign w_busy    = (r_state != S_IDLE);
  assign w_reg_wr  = stb & we;
  assign w_ctrl_wr = w_reg_wr & (addr == 2'd3);
  assign w_start   = w_ctrl_wr & data_in[0] & ~w_busy;
  // Final word: write accepted while exactly one word remains.
  assign w_last    = (r_state == S_WR) & m_ack & (r_cnt == 16'd1);
  // A zero-length start completes immediately without bus traffic.
  assign w_set_done = w_last | (w_start & (r_cnt == 16'd0));

  // Upper write-data bits have no register behind them.
  assign w_unused_data = ^data_in[31:22];

  assign ack = stb;
  assign irq = r_done & r_ie;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and master bus outputs.
  always_comb begin
    w_next = r_state;
    m_stb  = 1'b0;
    m_we   = 1'b0;
    m_addr = 22'd0;
    m_dout = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (w_start && (r_cnt != 16'd0)) begin
          w_next = w_fill ? S_WR : S_RD;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_RD: begin
        m_stb  = 1'b1;
        m_addr = r_src;
        if (m_ack) begin
          w_next = S_WR;
        end else begin
          w_next = S_RD;
        end
      end
      S_WR: begin
        m_stb  = 1'b1;
        m_we   = 1'b1;
        m_addr = r_dst;
        m_dout = w_fill ? {10'd0, r_src} : r_buf;
        if (m_ack) begin
          if (r_cnt == 16'd1) begin
            w_next = S_IDLE;
          end else begin
            // Next word starts straight away, no idle gap.
            w_next = w_fill ? S_WR : S_RD;
          end
        end else begin
          w_next = S_WR;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Channel registers, data buffer and control/status bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_src  <= 22'd0;
      r_dst  <= 22'd0;
      r_cnt  <= 16'd0;
      r_buf  <= 32'd0;
      r_ie   <= 1'b0;
      r_done <= 1'b0;
`ifdef DMA_FILL_EN
      r_fill <= 1'b0;
`endif
    end else begin
      // Channel setup is frozen while a transfer is running.
      if (w_reg_wr && !w_busy) begin
        case (addr)
          2'd0:    r_src <= data_in[21:0];
          2'd1:    r_dst <= data_in[21:0];
          2'd2:    r_cnt <= data_in[15:0];
          default: ;
        endcase
      end
      if ((r_state == S_RD) && m_ack) begin
        r_buf <= m_din;
      end
      if ((r_state == S_WR) && m_ack) begin
        if (!w_fill) begin
          r_src <= r_src + 22'd1;
        end
        r_dst <= r_dst + 22'd1;
        r_cnt <= r_cnt - 16'd1;
      end
      if (w_ctrl_wr) begin
        r_ie <= data_in[1];
      end
      // Completion wins over a same-cycle clear from software.
      if (w_set_done) begin
        r_done <= 1'b1;
      end else if (w_ctrl_wr) begin
        r_done <= 1'b0;
      end
`ifdef DMA_FILL_EN
      if (w_ctrl_wr && !w_busy) begin
        r_fill <= data_in[2];
      end
`endif
    end
  end

  // Register read-back mux.
  always_comb begin
    data_out = 32'd0;
    case (addr)
      2'd0:    data_out = {10'd0, r_src};
      2'd1:    data_out = {10'd0, r_dst};
      2'd2:    data_out = {16'd0, r_cnt};
`ifdef DMA_FILL_EN
      2'd3:    data_out = {28'd0, r_fill, r_ie, r_done, w_busy};
`else
      2'd3:    data_out = {29'd0, r_ie, r_done, w_busy};
`endif
      default: data_out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_dma.sv
// tb_dma -- directed self-checking bench for dma.
// Expected master transactions are queued before each transfer and compared
// as the bench's slave model accepts each access.

module tb_dma;

  logic         clk;
  logic         rst;
  logic         stb;
  logic         we;
  logic [3:2]   addr;
  logic [31:0]  data_in;
  logic [31:0]  data_out;
  logic         ack;
  logic         m_stb;
  logic         m_we;
  logic [23:2]  m_addr;
  logic [31:0]  m_din;
  logic [31:0]  m_dout;
  logic         m_ack;
  logic         irq;

  typedef struct packed {
    logic        we;
    logic [21:0] a;
    logic [31:0] d;
  } txn_t;

  txn_t sb[$];
  int   n_asserts = 0;
  int   n_fail    = 0;

  dma dut (
    .clk      (clk),
    .rst      (rst),
    .stb      (stb),
    .we       (we),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .ack      (ack),
    .m_stb    (m_stb),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_din    (m_din),
    .m_dout   (m_dout),
    .m_ack    (m_ack),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave read data pattern.
  function automatic logic [31:0] rdata(input logic [21:0] a);
    return 32'hC0DE_0000 ^ {10'd0, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    stb = 1'b1; we = 1'b1; addr = a; data_in = d;
    #1;
    check("ack_wr", {31'd0, ack}, 32'd1);
    @(posedge clk);
    #1;
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic reg_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    @(negedge clk);
    stb = 1'b1; we = 1'b0; addr = a;
    #1;
    check(tag, data_out, exp);
    stb = 1'b0;
  endtask

  task automatic push_copy(input logic [21:0] s, input logic [21:0] d, input int n);
    logic [21:0] sa;
    logic [21:0] da;
    sa = s; da = d;
    for (int i = 0; i < n; i++) begin
      sb.push_back('{1'b0, sa, 32'd0});
      sb.push_back('{1'b1, da, rdata(sa)});
      sa = sa + 22'd1;
      da = da + 22'd1;
    end
  endtask

  // Slave model: acks each access after wait_n low cycles, checks hold
  // stability during waits and matches accepted accesses against the queue.
  task automatic run(input int wait_n, input int budget);
    int   w;
    bit   newacc;
    bit   fin;
    txn_t snap;
    txn_t ex;
    w = 0; newacc = 1'b1; fin = 1'b0; addr = 2'd3;
    for (int c = 0; c < budget && !fin; c++) begin
      @(negedge clk);
      if (m_stb) begin
        if (newacc) begin
          snap = '{m_we, m_addr, m_dout};
          newacc = 1'b0;
          w = 0;
        end else begin
          check("hold_we",   {31'd0, m_we}, {31'd0, snap.we});
          check("hold_addr", {10'd0, m_addr}, {10'd0, snap.a});
          check("hold_dout", m_dout, snap.d);
        end
        if (w >= wait_n) begin
          m_ack = 1'b1;
          m_din = rdata(m_addr);
          check("sb_has_entry", {31'd0, (sb.size() > 0)}, 32'd1);
          if (sb.size() > 0) begin
            ex = sb.pop_front();
            check("acc_we",   {31'd0, m_we}, {31'd0, ex.we});
            check("acc_addr", {10'd0, m_addr}, {10'd0, ex.a});
            check("acc_data", m_dout, ex.d);
          end
          newacc = 1'b1;
        end else begin
          m_ack = 1'b0;
          w++;
        end
      end else begin
        m_ack = 1'b0;
        if (data_out[0] == 1'b0) fin = 1'b1;
      end
    end
    m_ack = 1'b0;
    check("run_done_in_budget", {31'd0, fin}, 32'd1);
    check("sb_drained", sb.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b1; stb = 1'b0; we = 1'b0; addr = 2'd0; data_in = 32'd0;
    m_din = 32'd0; m_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_m_stb", {31'd0, m_stb}, 32'd0);
    check("rst_m_we",  {31'd0, m_we}, 32'd0);
    check("rst_m_addr", {10'd0, m_addr}, 32'd0);
    check("rst_m_dout", m_dout, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    reg_rd("rst_src", 2'd0, 32'd0);
    reg_rd("rst_dst", 2'd1, 32'd0);
    reg_rd("rst_cnt", 2'd2, 32'd0);
    reg_rd("rst_ctrl", 2'd3, 32'd0);

    // Basic copy, zero-wait slave
    reg_wr(2'd0, 32'h100);
    reg_wr(2'd1, 32'h200);
    reg_wr(2'd2, 32'd3);
    push_copy(22'h100, 22'h200, 3);
    reg_wr(2'd3, 32'h1);
    run(0, 100);
    reg_rd("copy_src", 2'd0, 32'h103);
    reg_rd("copy_dst", 2'd1, 32'h203);
    reg_rd("copy_cnt", 2'd2, 32'd0);
    reg_rd("copy_ctrl", 2'd3, 32'h2);

    // Wait states
    reg_wr(2'd0, 32'h40);
    reg_wr(2'd1, 32'h80);
    reg_wr(2'd2, 32'd2);
    push_copy(22'h40, 22'h80, 2);
    reg_wr(2'd3, 32'h1);
    run(5, 200);
    reg_rd("wait_dst", 2'd1, 32'h82);

    // Interrupt
    reg_wr(2'd0, 32'h10);
    reg_wr(2'd1, 32'h20);
    reg_wr(2'd2, 32'd1);
    push_copy(22'h10, 22'h20, 1);
    reg_wr(2'd3, 32'h3);
    run(0, 100);
    check("irq_set", {31'd0, irq}, 32'd1);
    reg_wr(2'd3, 32'h2);
    check("irq_clr", {31'd0, irq}, 32'd0);
    reg_rd("irq_ctrl_ie", 2'd3, 32'h4);

    // Zero count completes next edge without bus activity
    reg_wr(2'd2, 32'd0);
    reg_wr(2'd3, 32'h1);
    check("cnt0_m_stb", {31'd0, m_stb}, 32'd0);
    reg_rd("cnt0_ctrl", 2'd3, 32'h2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("cnt0_idle_bus", {31'd0, m_stb}, 32'd0);
    end

    // Address wrap
    reg_wr(2'd0, 32'h3F_FFFF);
    reg_wr(2'd1, 32'h300);
    reg_wr(2'd2, 32'd2);
    push_copy(22'h3F_FFFF, 22'h300, 2);
    reg_wr(2'd3, 32'h1);
    run(0, 100);
    reg_rd("wrap_src", 2'd0, 32'h1);
    reg_rd("wrap_dst", 2'd1, 32'h302);

    // DST write while busy is ignored
    reg_wr(2'd0, 32'h500);
    reg_wr(2'd1, 32'h600);
    reg_wr(2'd2, 32'd2);
    reg_wr(2'd3, 32'h1);
    reg_wr(2'd1, 32'h7777);
    reg_rd("busy_dst_kept", 2'd1, 32'h600);
    reg_rd("busy_ctrl", 2'd3, 32'h1);
    push_copy(22'h500, 22'h600, 2);
    run(0, 100);

    // Reset in the middle of a write
    reg_wr(2'd0, 32'h10);
    reg_wr(2'd1, 32'h20);
    reg_wr(2'd2, 32'd2);
    reg_wr(2'd3, 32'h3);
    @(negedge clk);
    check("mid_rd_stb", {31'd0, m_stb}, 32'd1);
    m_ack = 1'b1;
    m_din = rdata(m_addr);
    @(negedge clk);
    m_ack = 1'b0;
    check("mid_wr_we", {31'd0, m_we}, 32'd1);
    check("mid_wr_dout", m_dout, rdata(22'h10));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_m_stb", {31'd0, m_stb}, 32'd0);
    check("mid_rst_m_we", {31'd0, m_we}, 32'd0);
    check("mid_rst_m_addr", {10'd0, m_addr}, 32'd0);
    check("mid_rst_m_dout", m_dout, 32'd0);
    check("mid_rst_irq", {31'd0, irq}, 32'd0);
    reg_rd("mid_rst_src", 2'd0, 32'd0);
    reg_rd("mid_rst_dst", 2'd1, 32'd0);
    reg_rd("mid_rst_cnt", 2'd2, 32'd0);
    reg_rd("mid_rst_ctrl", 2'd3, 32'd0);

`ifdef DMA_FILL_EN
    // Fill mode
    reg_wr(2'd0, 32'hABCD);
    reg_wr(2'd1, 32'h10);
    reg_wr(2'd2, 32'd4);
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{1'b1, 22'h10 + 22'(i), 32'h0000_ABCD});
    end
    reg_wr(2'd3, 32'h5);
    run(0, 100);
    reg_rd("fill_src", 2'd0, 32'hABCD);
    reg_rd("fill_dst", 2'd1, 32'h14);
    reg_rd("fill_ctrl", 2'd3, 32'hA);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
